ucode_sequencer: RTL and testbench
==================================

Name: ucode_sequencer

Overview:
Parametrised microcode sequencer. It fetches microwords from an external synchronous microcode memory and presents each decoded word to the datapath over a valid/ready handshake. It resolves control flow: sequential execution, unconditional jump, jump-on-zero, and call/return through a bounded return stack. It sits between the top-level controller (start/abort/done) and the register-file/ALU/DMEM datapath.

Parameters:
REG_AW, 4, register-file port address width
ALU_OPW, 4, ALU opcode width
IMM_W, 8, immediate width; the low UPC_W bits also form the jump/call target (zero-extended if IMM_W < UPC_W)
UPC_W, 8, micro-PC width; microcode depth is 2**UPC_W
STACK_DEPTH, 4, return-stack entries; must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sequence at start_addr; honoured only in IDLE
start_addr  in  UPC_W  entry micro-address
abort  in  1  flush to IDLE; highest priority in every state
umem_en  out  1  microcode memory read enable
umem_addr  out  UPC_W  microcode read address
umem_rdata  in  UW  microword, valid the cycle after umem_en; UW = 2*REG_AW+ALU_OPW+IMM_W+14
op_valid  out  1  decoded op present
op_ready  in  1  datapath accepts op
op  out  UW  microword as ucode_word_t
alu_zero  in  1  registered datapath zero flag, sampled on op fire
busy  out  1  state != IDLE
seq_done  out  1  one-cycle pulse when a DONE op fires
error  out  1  sticky; set on return-stack overflow or underflow

Behaviour:
- Reset values: state=IDLE, uPC=0, stack empty, op=0, and every output 0.
- States: IDLE, FETCH, ISSUE, HALT. Everything is registered; no combinational path runs from op_ready to op_valid.
- IDLE: on start, load uPC=start_addr and go to FETCH.
- FETCH (1 cycle): umem_en=1, umem_addr=uPC. Next cycle, capture umem_rdata into the op register and go to ISSUE.
- ISSUE: op_valid=1. op and op_valid stay stable until fire (op_valid&&op_ready).
- Peak throughput is 1 op per 2 cycles. Back-to-back ops alternate FETCH/ISSUE.
- On fire, next uPC is chosen with this priority:
  - done: go to IDLE and pulse seq_done next cycle. No control-flow evaluation, no stack change.
  - ret: if the stack is empty, go to HALT and set error. Otherwise uPC=pop.
  - call: if the stack is full, go to HALT and set error. Otherwise push uPC+1 and set uPC=target.
  - jmp: uPC=target.
  - jz: if alu_zero=1, uPC=target; otherwise uPC+1.
  - none of the above: uPC+1.
  - After any non-done, non-error case, go to FETCH.
- uPC+1 wraps modulo 2**UPC_W. The pushed return address wraps identically.
- HALT: op_valid=0 and busy=1. Only abort or reset leaves HALT.
- abort: next cycle state=IDLE, op_valid=0, stack cleared, error cleared. An op presented in that cycle is dropped even if op_ready=1; abort wins. If start and abort are asserted together in IDLE, abort wins and start is ignored.
- start outside IDLE is ignored.
- Reset mid-sequence: immediate return to reset values, with no seq_done pulse.

Decomposition:
- Package ucode_pkg holds:
  - field width localparams;
  - ucode_word_t packed struct, MSB to LSB: porta_reg, portb_reg, porta_we, alu_op, alu_use_imm, alu_shift_right, jz, jmp, call, ret, in_alu, in_rf, in_dmem, in_imm, out_rf_wr, out_dm_wr, done, imm;
  - seq_state_t enum;
  - the target-extraction function.
- Sub-module ucode_ret_stack (parameters STACK_DEPTH, UPC_W): push, pop, clear, top, full, empty. The stack is a register array with a pointer. Simultaneous push and pop is illegal and assertion-checked.

Test Plan:
- Sequential run with immediate stall: start with start_addr=0x10; words 0x10..0x12 are plain ops and 0x13 has done; op_ready=1 except a 3-cycle stall on 0x11. Required: umem_addr sequence 10,11,12,13, op held stable during the stall, seq_done pulses once, busy falls the same cycle.
- Jump-on-zero, both outcomes: jz at 0x05 with imm=0x40. With alu_zero=1 the next fetch is 0x40; with alu_zero=0 it is 0x06. Unconditional jmp imm=0x7F goes to 0x7F.
- Call/return with wrap: call at 0xFF, target 0x20; ret at 0x20. Required: returns to 0x00 (wrap), stack empty afterwards, error=0.
- Overflow: 5 nested calls with STACK_DEPTH=4. Required: the 5th call fires, then state=HALT, error=1, op_valid=0, busy=1. Then abort: IDLE, error=0.
- Underflow: ret as the first op. Required: HALT and error=1.
- Abort in ISSUE with op_ready=1 in the same cycle: no seq_done, op_valid=0 next cycle, IDLE. A start arriving 1 cycle later is accepted.
- Reset asserted asynchronously in the FETCH state: all outputs 0 immediately.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared types for the microcode sequencer: microword layout, FSM states and
// the jump/call target extraction helper.
package ucode_pkg;

  localparam int UC_REG_AW      = 4;
  localparam int UC_ALU_OPW     = 4;
  localparam int UC_IMM_W       = 8;
  localparam int UC_UPC_W       = 8;
  localparam int UC_STACK_DEPTH = 4;
  localparam int UC_UW          = 2*UC_REG_AW + UC_ALU_OPW + UC_IMM_W + 14;
  localparam int UC_EXT_W       = (UC_IMM_W > UC_UPC_W) ? UC_IMM_W : UC_UPC_W;

  typedef struct packed {
    logic [UC_REG_AW-1:0]  porta_reg;
    logic [UC_REG_AW-1:0]  portb_reg;
    logic                  porta_we;
    logic [UC_ALU_OPW-1:0] alu_op;
    logic                  alu_use_imm;
    logic                  alu_shift_right;
    logic                  jz;
    logic                  jmp;
    logic                  call;
    logic                  ret;
    logic                  in_alu;
    logic                  in_rf;
    logic                  in_dmem;
    logic                  in_imm;
    logic                  out_rf_wr;
    logic                  out_dm_wr;
    logic                  done;
    logic [UC_IMM_W-1:0]   imm;
  } ucode_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  // Low UPC_W bits of the immediate, zero-extended when the immediate is narrower.
  function automatic logic [UC_UPC_W-1:0] target_of(input logic [UC_IMM_W-1:0] imm);
    logic [UC_EXT_W-1:0] ext;
    ext = UC_EXT_W'(imm);
    return ext[UC_UPC_W-1:0];
  endfunction

endpackage

// File: rtl/ucode_if.sv
// Microcode-memory port and decoded-op handshake between sequencer and datapath.
interface ucode_if
  import ucode_pkg::*;
#(
  parameter int UPC_W = UC_UPC_W,
  parameter int UW    = UC_UW
);
  logic             umem_en;
  logic [UPC_W-1:0] umem_addr;
  logic [UW-1:0]    umem_rdata;
  logic             op_valid;
  logic             op_ready;
  ucode_word_t      op;
  logic             alu_zero;

  modport master (
    output umem_en, umem_addr, op_valid, op,
    input  umem_rdata, op_ready, alu_zero
  );

  modport slave (
    input  umem_en, umem_addr, op_valid, op,
    output umem_rdata, op_ready, alu_zero
  );
endinterface

// File: rtl/ucode_ret_stack.sv
// Bounded return-address stack: register array addressed by an occupancy pointer.
module ucode_ret_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int UPC_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [UPC_W-1:0] data,
  output logic [UPC_W-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UPC_W-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]    ptr;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign wr_idx = IW'(ptr);
  assign rd_idx = IW'(ptr - PW'(1));
  assign full   = (ptr == PW'(STACK_DEPTH));
  assign empty  = (ptr == '0);
  assign top    = mem[rd_idx];

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= '0;
    else if (clear)            ptr <= '0;
    else if (push && !full)    ptr <= ptr + PW'(1);
    else if (pop && !empty)    ptr <= ptr - PW'(1);
  end

  // NOTE: the entry array is deliberately not reset; ptr alone decides which
  // entries are meaningful, so clearing the storage would only cost flops.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wr_idx] <= data;
  end

  a_no_push_pop: assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches microwords, issues them over valid/ready and
// resolves sequential, jump, jump-on-zero and call/return control flow.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int REG_AW      = UC_REG_AW,
  parameter int ALU_OPW     = UC_ALU_OPW,
  parameter int IMM_W       = UC_IMM_W,
  parameter int UPC_W       = UC_UPC_W,
  parameter int STACK_DEPTH = UC_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [UPC_W-1:0] start_addr,
  input  logic             abort,
  ucode_if.master          bus,
  output logic             busy,
  output logic             seq_done,
  output logic             error
);
  localparam int UW = 2*REG_AW + ALU_OPW + IMM_W + 14;

  seq_state_t       state, state_next;
  logic [UPC_W-1:0] upc, upc_next, upc_inc, target, stk_top;
  logic [UW-1:0]    rdata;
  ucode_word_t      op_q;
  logic             fire, push, pop, full, empty, err_set, done_fire;

  assign rdata   = bus.umem_rdata;
  assign upc_inc = upc + UPC_W'(1);
  assign target  = target_of(op_q.imm);
  assign fire    = (state == ST_ISSUE) && bus.op_ready;

  ucode_ret_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .UPC_W      (UPC_W)
  ) u_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .clear(abort),
    .data (upc_inc),
    .top  (stk_top),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      upc      <= '0;
      op_q     <= '0;
      error    <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_next;
      upc      <= upc_next;
      seq_done <= done_fire;
      if (abort)        error <= 1'b0;
      else if (err_set) error <= 1'b1;
      if (state == ST_FETCH) op_q <= rdata;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    upc_next   = upc;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    done_fire  = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_next = ST_FETCH;
        upc_next   = start_addr;
      end
      ST_FETCH: state_next = ST_ISSUE;
      ST_ISSUE: if (fire) begin
        state_next = ST_FETCH;
        if (op_q.done) begin
          state_next = ST_IDLE;
          done_fire  = 1'b1;
        end else if (op_q.ret) begin
          if (empty) begin
            state_next = ST_HALT;
            err_set    = 1'b1;
          end else begin
            pop      = 1'b1;
            upc_next = stk_top;
          end
        end else if (op_q.call) begin
          if (full) begin
            state_next = ST_HALT;
            err_set    = 1'b1;
          end else begin
            push     = 1'b1;
            upc_next = target;
          end
        end else if (op_q.jmp || (op_q.jz && bus.alu_zero)) begin
          upc_next = target;
        end else begin
          upc_next = upc_inc;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides whatever the op would have done, including a firing DONE.
    if (abort) begin
      state_next = ST_IDLE;
      upc_next   = upc;
      push       = 1'b0;
      pop        = 1'b0;
      err_set    = 1'b0;
      done_fire  = 1'b0;
    end
  end

  always_comb begin
    bus.umem_en   = (state == ST_FETCH);
    bus.umem_addr = (state == ST_FETCH) ? upc : '0;
    bus.op_valid  = (state == ST_ISSUE);
    busy          = (state != ST_IDLE);
  end

  assign bus.op = op_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: table of single-op control-flow vectors
// plus hand-written multi-cycle sequences (stall, call/ret wrap, overflow, abort, reset).
module tb_ucode_sequencer;
  import ucode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic       abort;
  logic       busy, seq_done, error;

  int checks = 0;
  int errors = 0;

  ucode_word_t umem [256];
  logic [7:0]  fetch_q[$];
  int          run_done;
  logic        run_halted;

  ucode_if bus ();

  ucode_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .seq_done  (seq_done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Word for the address driven in FETCH is ready before the sequencer's capturing edge.
  always @(negedge clk) if (bus.umem_en) bus.umem_rdata <= umem[bus.umem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ucode_word_t w_ctl(input logic d, input logic r, input logic c,
                                        input logic j, input logic z, input logic [7:0] imm);
    ucode_word_t w;
    w        = '0;
    w.done   = d;
    w.ret    = r;
    w.call   = c;
    w.jmp    = j;
    w.jz     = z;
    w.in_alu = 1'b1;
    w.imm    = imm;
    return w;
  endfunction

  function automatic ucode_word_t w_plain(input logic [7:0] imm);
    return w_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, imm);
  endfunction

  task automatic clear_mem();
    foreach (umem[i]) umem[i] = '0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Runs from sa with op_ready mirroring op_valid until DONE or HALT, within budget cycles.
  task automatic run_prog(input logic [7:0] sa, input int budget);
    fetch_q.delete();
    run_done   = 0;
    run_halted = 1'b0;
    start = 1'b1; start_addr = sa;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.umem_en) fetch_q.push_back(bus.umem_addr);
      if (seq_done) begin run_done++; break; end
      if (busy && !bus.umem_en && !bus.op_valid) begin run_halted = 1'b1; break; end
      bus.op_ready = bus.op_valid;
    end
    bus.op_ready = 1'b0;
    check($sformatf("run 0x%0h ended", sa), 64'(run_done != 0 || run_halted), 64'd1);
  endtask

  typedef enum {K_FETCH, K_HALT, K_IDLE} kind_t;
  typedef struct {
    logic [7:0]  at;
    ucode_word_t word;
    logic        zero;
    kind_t       kind;
    logic [7:0]  exp_addr;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{8'h30, w_plain(8'h99),                          1'b0, K_FETCH, 8'h31};
    vecs[1]  = '{8'h05, w_ctl(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h40),  1'b1, K_FETCH, 8'h40};
    vecs[2]  = '{8'h05, w_ctl(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h40),  1'b0, K_FETCH, 8'h06};
    vecs[3]  = '{8'h05, w_ctl(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h7F),  1'b0, K_FETCH, 8'h7F};
    vecs[4]  = '{8'h50, w_ctl(1'b0,1'b0,1'b1,1'b0,1'b0, 8'h20),  1'b0, K_FETCH, 8'h20};
    vecs[5]  = '{8'h08, w_ctl(1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00),  1'b0, K_HALT,  8'h00};
    vecs[6]  = '{8'hFF, w_plain(8'h01),                          1'b0, K_FETCH, 8'h00};
    vecs[7]  = '{8'h60, w_ctl(1'b1,1'b0,1'b0,1'b1,1'b0, 8'h60),  1'b1, K_IDLE,  8'h00};
    vecs[8]  = '{8'h09, w_ctl(1'b0,1'b1,1'b1,1'b0,1'b0, 8'h10),  1'b0, K_HALT,  8'h00};
    vecs[9]  = '{8'h0A, w_ctl(1'b0,1'b0,1'b0,1'b1,1'b1, 8'h33),  1'b0, K_FETCH, 8'h33};
    vecs[10] = '{8'hFF, w_ctl(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h12),  1'b0, K_FETCH, 8'h00};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; abort = 1'b0;
    bus.op_ready = 1'b0; bus.alu_zero = 1'b0; bus.umem_rdata = '0;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 0);
    check("rst op_valid", 64'(bus.op_valid), 0);
    check("rst umem_en", 64'(bus.umem_en), 0);
    check("rst umem_addr", 64'(bus.umem_addr), 0);
    check("rst op", 64'(bus.op), 0);
    check("rst seq_done", 64'(seq_done), 0);
    check("rst error", 64'(error), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-op control-flow vectors
    for (int i = 0; i < NV; i++) begin
      go_idle();
      clear_mem();
      umem[vecs[i].at] = vecs[i].word;
      start = 1'b1; start_addr = vecs[i].at;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d fetch addr", i), 64'(bus.umem_addr), 64'(vecs[i].at));
      @(posedge clk); #1;
      bus.op_ready = 1'b1; bus.alu_zero = vecs[i].zero;
      @(negedge clk);
      check($sformatf("v%0d op_valid", i), 64'(bus.op_valid), 1);
      check($sformatf("v%0d op", i), 64'(bus.op), 64'(vecs[i].word));
      @(posedge clk); #1;
      bus.op_ready = 1'b0; bus.alu_zero = 1'b0;
      @(negedge clk);
      case (vecs[i].kind)
        K_FETCH: begin
          check($sformatf("v%0d next umem_en", i), 64'(bus.umem_en), 1);
          check($sformatf("v%0d next addr", i), 64'(bus.umem_addr), 64'(vecs[i].exp_addr));
          check($sformatf("v%0d error", i), 64'(error), 0);
        end
        K_HALT: begin
          check($sformatf("v%0d halt busy", i), 64'(busy), 1);
          check($sformatf("v%0d halt op_valid", i), 64'(bus.op_valid), 0);
          check($sformatf("v%0d halt umem_en", i), 64'(bus.umem_en), 0);
          check($sformatf("v%0d halt error", i), 64'(error), 1);
        end
        default: begin
          check($sformatf("v%0d done busy", i), 64'(busy), 0);
          check($sformatf("v%0d seq_done", i), 64'(seq_done), 1);
        end
      endcase
    end

    // Sequential run 0x10..0x13 with a 3-cycle stall on 0x11
    begin
      int stall, post, dcnt;
      go_idle();
      clear_mem();
      for (int a = 8'h10; a <= 8'h12; a++) umem[a] = w_plain(8'(a));
      umem[8'h13] = w_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13);
      fetch_q.delete();
      stall = 0; post = 0; dcnt = 0;
      start = 1'b1; start_addr = 8'h10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 40 && post < 3; c++) begin
        @(negedge clk);
        if (bus.umem_en) fetch_q.push_back(bus.umem_addr);
        if (seq_done) begin
          dcnt++;
          check("seq busy at done", 64'(busy), 0);
        end
        if (dcnt > 0) post++;
        if (bus.op_valid && bus.op.imm == 8'h11 && stall < 3) begin
          check($sformatf("seq stall hold %0d", stall), 64'(bus.op), 64'(w_plain(8'h11)));
          stall++;
          bus.op_ready = 1'b0;
        end else begin
          bus.op_ready = bus.op_valid;
        end
      end
      bus.op_ready = 1'b0;
      check("seq done pulses", 64'(dcnt), 1);
      check("seq stall cycles", 64'(stall), 3);
      check("seq fetch count", 64'(fetch_q.size()), 4);
      for (int j = 0; j < 4; j++)
        if (j < fetch_q.size())
          check($sformatf("seq fetch %0d", j), 64'(fetch_q[j]), 64'(8'h10 + j));
    end

    // Call at 0xFF returns to 0x00 by wrap; stack must then be empty
    go_idle();
    clear_mem();
    umem[8'hFF] = w_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
    umem[8'h20] = w_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    umem[8'h00] = w_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_prog(8'hFF, 30);
    check("call done", 64'(run_done), 1);
    check("call fetch count", 64'(fetch_q.size()), 3);
    if (fetch_q.size() == 3) begin
      check("call fetch 0", 64'(fetch_q[0]), 64'hFF);
      check("call fetch 1", 64'(fetch_q[1]), 64'h20);
      check("call fetch 2", 64'(fetch_q[2]), 64'h00);
    end
    check("call error", 64'(error), 0);
    run_prog(8'h20, 20);
    check("stack empty after ret", 64'(run_halted), 1);
    check("stack empty error", 64'(error), 1);

    // Overflow: five nested calls against four entries
    go_idle();
    clear_mem();
    for (int a = 1; a <= 5; a++) umem[a] = w_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(a + 1));
    run_prog(8'h01, 40);
    check("ovf halted", 64'(run_halted), 1);
    check("ovf fetch count", 64'(fetch_q.size()), 5);
    check("ovf error", 64'(error), 1);
    check("ovf op_valid", 64'(bus.op_valid), 0);
    check("ovf busy", 64'(busy), 1);
    @(posedge clk); #1;
    check("ovf still halted", 64'(busy), 1);
    go_idle();
    @(negedge clk);
    check("ovf abort busy", 64'(busy), 0);
    check("ovf abort error", 64'(error), 0);

    // Abort in ISSUE with op_ready high drops a DONE op; start one cycle later is taken
    clear_mem();
    umem[8'h70] = w_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b1; start_addr = 8'h70;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1; bus.op_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bus.op_ready = 1'b0;
    start = 1'b1; start_addr = 8'h30;
    @(negedge clk);
    check("abort seq_done", 64'(seq_done), 0);
    check("abort op_valid", 64'(bus.op_valid), 0);
    check("abort busy", 64'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart umem_en", 64'(bus.umem_en), 1);
    check("restart addr", 64'(bus.umem_addr), 64'h30);
    check("restart seq_done", 64'(seq_done), 0);

    // start together with abort in IDLE: abort wins
    go_idle();
    start = 1'b1; abort = 1'b1; start_addr = 8'h44;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start+abort busy", 64'(busy), 0);
    check("start+abort umem_en", 64'(bus.umem_en), 0);

    // Asynchronous reset in FETCH
    start = 1'b1; start_addr = 8'h44;
    @(posedge clk); #1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", 64'(busy), 0);
    check("arst umem_en", 64'(bus.umem_en), 0);
    check("arst umem_addr", 64'(bus.umem_addr), 0);
    check("arst op_valid", 64'(bus.op_valid), 0);
    check("arst op", 64'(bus.op), 0);
    check("arst error", 64'(error), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst seq_done", 64'(seq_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
